// File: rtl/cache_axi_refill.sv
// Line refill engine: optional 16-beat victim write-back, then 16-beat AXI read refill.
// Latency: refresh 18 cycles after miss is sampled (clean), 36 with write-back (zero-wait slave).
// Backpressure: every valid holds with stable addr/data until ready; miss is ignored while busy.
module cache_axi_refill (
    input  logic         clk,
    input  logic         resetn,
    input  logic         miss,
    input  logic         write_back,
    input  logic [31:0]  axi_raddr,
    input  logic [31:0]  axi_waddr,
    input  logic [511:0] wb_line,
    output logic         refresh,
    output logic [511:0] refill_line,
    output logic         busy,
    output logic [31:0]  araddr,
    output logic [7:0]   arlen,
    output logic         arvalid,
    input  logic         arready,
    input  logic [31:0]  rdata,
    input  logic         rvalid,
    input  logic         rlast,
    output logic         rready,
    output logic [31:0]  awaddr,
    output logic [7:0]   awlen,
    output logic         awvalid,
    input  logic         awready,
    output logic [31:0]  wdata,
    output logic         wlast,
    output logic         wvalid,
    input  logic         wready,
    input  logic         bvalid,
    output logic         bready
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_AW,
        S_W,
        S_B,
        S_AR,
        S_R,
        S_DONE
    } state_t;

    state_t         state;
    logic [3:0]     cnt;
    logic [31:0]    raddr_q;
    logic [31:0]    waddr_q;
    logic [511:0]   wb_q;

    // Bursts are always a full line; addresses come straight from the captured registers
    // so they cannot move while a valid is waiting for its ready.
    assign arlen  = 8'd15;
    assign awlen  = 8'd15;
    assign araddr = raddr_q;
    assign awaddr = waddr_q;

    // Write data is the captured victim word selected by the beat counter; cnt only moves
    // on a W handshake, so wdata is stable while wvalid waits.
    assign wdata  = wb_q[{cnt, 5'b0} +: 32];

    // Refill sequencer: state, beat counter, captured request and all handshake outputs.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state       <= S_IDLE;
            cnt         <= 4'd0;
            raddr_q     <= 32'd0;
            waddr_q     <= 32'd0;
            wb_q        <= 512'd0;
            refill_line <= 512'd0;
            refresh     <= 1'b0;
            busy        <= 1'b0;
            arvalid     <= 1'b0;
            rready      <= 1'b0;
            awvalid     <= 1'b0;
            wvalid      <= 1'b0;
            wlast       <= 1'b0;
            bready      <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (miss) begin
                        raddr_q <= axi_raddr;
                        waddr_q <= axi_waddr;
                        wb_q    <= wb_line;
                        cnt     <= 4'd0;
                        busy    <= 1'b1;
                        if (write_back) begin
                            awvalid <= 1'b1;
                            state   <= S_AW;
                        end else begin
                            arvalid <= 1'b1;
                            state   <= S_AR;
                        end
                    end
                end
                S_AW: begin
                    if (awready) begin
                        awvalid <= 1'b0;
                        wvalid  <= 1'b1;
                        wlast   <= 1'b0;
                        state   <= S_W;
                    end
                end
                S_W: begin
                    if (wready) begin
                        if (wlast) begin
                            wvalid <= 1'b0;
                            wlast  <= 1'b0;
                            cnt    <= 4'd0;
                            bready <= 1'b1;
                            state  <= S_B;
                        end else begin
                            cnt   <= cnt + 4'd1;
                            wlast <= (cnt == 4'd14);
                        end
                    end
                end
                S_B: begin
                    if (bvalid) begin
                        bready  <= 1'b0;
                        arvalid <= 1'b1;
                        state   <= S_AR;
                    end
                end
                S_AR: begin
                    if (arready) begin
                        arvalid <= 1'b0;
                        rready  <= 1'b1;
                        state   <= S_R;
                    end
                end
                S_R: begin
                    if (rvalid) begin
                        refill_line[{cnt, 5'b0} +: 32] <= rdata;
                        // rlast ends the burst regardless of the beat count; the
                        // counter simply wraps if the slave sends more than 16 beats.
                        if (rlast) begin
                            cnt     <= 4'd0;
                            rready  <= 1'b0;
                            refresh <= 1'b1;
                            state   <= S_DONE;
                        end else begin
                            cnt <= cnt + 4'd1;
                        end
                    end
                end
                S_DONE: begin
                    refresh <= 1'b0;
                    busy    <= 1'b0;
                    state   <= S_IDLE;
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_cache_axi_refill.sv
// Bench for cache_axi_refill: table vectors, randomized stalled transactions, reset mid-burst.
// A transaction-level reference model predicts the line, beat order and latencies.
// A behavioural AXI slave drives ready/valid with optional random stalls.
module tb_cache_axi_refill;

    logic         clk = 1'b0;
    logic         resetn;
    logic         miss;
    logic         write_back;
    logic [31:0]  axi_raddr;
    logic [31:0]  axi_waddr;
    logic [511:0] wb_line;
    logic         refresh;
    logic [511:0] refill_line;
    logic         busy;
    logic [31:0]  araddr;
    logic [7:0]   arlen;
    logic         arvalid;
    logic         arready;
    logic [31:0]  rdata;
    logic         rvalid;
    logic         rlast;
    logic         rready;
    logic [31:0]  awaddr;
    logic [7:0]   awlen;
    logic         awvalid;
    logic         awready;
    logic [31:0]  wdata;
    logic         wlast;
    logic         wvalid;
    logic         wready;
    logic         bvalid;
    logic         bready;

    always #5 clk = ~clk;

    cache_axi_refill dut (
        .clk(clk), .resetn(resetn), .miss(miss), .write_back(write_back),
        .axi_raddr(axi_raddr), .axi_waddr(axi_waddr), .wb_line(wb_line),
        .refresh(refresh), .refill_line(refill_line), .busy(busy),
        .araddr(araddr), .arlen(arlen), .arvalid(arvalid), .arready(arready),
        .rdata(rdata), .rvalid(rvalid), .rlast(rlast), .rready(rready),
        .awaddr(awaddr), .awlen(awlen), .awvalid(awvalid), .awready(awready),
        .wdata(wdata), .wlast(wlast), .wvalid(wvalid), .wready(wready),
        .bvalid(bvalid), .bready(bready)
    );

    typedef struct {
        bit          wb;
        logic [31:0] raddr;
        logic [31:0] waddr;
        bit          zw;
        int          rlen;
        int          pat;
        int          exp_lat;
    } vec_t;

    int n_checks = 0;
    int n_pass   = 0;
    int n_fail   = 0;
    int cyc      = 0;

    // slave configuration and observations
    bit          zw;
    bit          exp_wb;
    int          s_rlen;
    logic [31:0] s_rbeats [0:31];
    logic [31:0] wbw [0:15];
    int          ar_cnt, aw_cnt, w_cnt, r_cnt, b_cnt, stable_viol;
    bit          ar_before_b;
    logic [31:0] ar_addr_seen, aw_addr_seen;
    logic [7:0]  arlen_seen, awlen_seen;
    logic [32:0] w_seen [0:31];
    bit          b_pend, b_taken, r_taken, rd_act;
    int          rd_idx;
    bit          prev_ar_stall, prev_aw_stall, prev_w_stall;
    logic [31:0] prev_araddr, prev_awaddr, prev_wdata;
    logic        prev_wlast;

    logic [511:0] ref_line;

    initial forever begin
        @(posedge clk);
        cyc++;
    end

    task automatic chk(input string name, input logic [511:0] act, input logic [511:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end else begin
            n_pass++;
        end
    endtask

    // Behavioural AXI slave; everything decided at the falling edge for the next rising edge.
    initial begin
        arready = 0; awready = 0; wready = 0; bvalid = 0; rvalid = 0; rlast = 0; rdata = 0;
        b_pend = 0; b_taken = 0; r_taken = 0; rd_act = 0; rd_idx = 0;
        prev_ar_stall = 0; prev_aw_stall = 0; prev_w_stall = 0;
        prev_araddr = 0; prev_awaddr = 0; prev_wdata = 0; prev_wlast = 0;
        forever begin
            @(negedge clk);
            if (!resetn) begin
                arready = 0; awready = 0; wready = 0; bvalid = 0; rvalid = 0; rlast = 0;
                b_pend = 0; b_taken = 0; r_taken = 0; rd_act = 0; rd_idx = 0;
                prev_ar_stall = 0; prev_aw_stall = 0; prev_w_stall = 0;
                continue;
            end
            if (prev_ar_stall && (!arvalid || araddr !== prev_araddr)) stable_viol++;
            if (prev_aw_stall && (!awvalid || awaddr !== prev_awaddr)) stable_viol++;
            if (prev_w_stall && (!wvalid || wdata !== prev_wdata || wlast !== prev_wlast)) stable_viol++;
            if (b_taken) begin bvalid = 0; b_taken = 0; end
            if (r_taken) begin
                rvalid = 0; rlast = 0; r_taken = 0; rd_idx++;
                if (rd_idx >= s_rlen) rd_act = 0;
            end
            arready = zw ? 1'b1 : ($urandom_range(0, 2) != 0);
            awready = zw ? 1'b1 : ($urandom_range(0, 2) != 0);
            wready  = zw ? 1'b1 : ($urandom_range(0, 2) != 0);
            if (b_pend && !bvalid) bvalid = zw ? 1'b1 : ($urandom_range(0, 2) != 0);
            if (rd_act && !rvalid) begin
                rvalid = zw ? 1'b1 : ($urandom_range(0, 2) != 0);
                rdata  = s_rbeats[rd_idx];
                rlast  = rvalid && (rd_idx == s_rlen - 1);
            end
            if (arvalid && exp_wb && b_cnt == 0) ar_before_b = 1;
            if (awvalid && awready) begin aw_cnt++; aw_addr_seen = awaddr; awlen_seen = awlen; end
            if (wvalid && wready) begin
                if (w_cnt < 32) w_seen[w_cnt] = {wlast, wdata};
                w_cnt++;
                if (wlast) b_pend = 1;
            end
            if (bvalid && bready) begin b_cnt++; b_pend = 0; b_taken = 1; end
            if (arvalid && arready) begin
                ar_cnt++; ar_addr_seen = araddr; arlen_seen = arlen;
                rd_act = 1; rd_idx = 0;
            end
            if (rvalid && rready) begin r_cnt++; r_taken = 1; end
            prev_ar_stall = arvalid && !arready; prev_araddr = araddr;
            prev_aw_stall = awvalid && !awready; prev_awaddr = awaddr;
            prev_w_stall  = wvalid && !wready;   prev_wdata = wdata; prev_wlast = wlast;
        end
    end

    // One refill transaction; reset_beat > 0 pulses reset once that many R beats are seen.
    task automatic run_txn(input vec_t v, input bit scramble, input int reset_beat, input string tag);
        int  miss_edge;
        bit  found;
        logic [31:0] tmp;
        @(negedge clk); #1;
        zw = v.zw; s_rlen = v.rlen; exp_wb = v.wb;
        for (int k = 0; k < 32; k++) s_rbeats[k] = (v.pat == 0) ? k : $urandom;
        for (int k = 0; k < 16; k++) wbw[k] = (v.pat == 0) ? (32'hA000_0000 + k) : $urandom;
        ar_cnt = 0; aw_cnt = 0; w_cnt = 0; r_cnt = 0; b_cnt = 0; stable_viol = 0; ar_before_b = 0;
        write_back = v.wb; axi_raddr = v.raddr; axi_waddr = v.waddr;
        for (int k = 0; k < 16; k++) wb_line[k*32 +: 32] = wbw[k];
        chk({tag, "_idle_before"}, busy, 0);
        miss = 1;
        miss_edge = cyc + 1;
        found = 0;
        for (int i = 0; i < 4000; i++) begin
            @(negedge clk); #1;
            if (i == 0) chk({tag, "_busy"}, busy, 1);
            if (scramble) begin
                tmp = $urandom; write_back = tmp[0];
                axi_raddr = $urandom; axi_waddr = $urandom;
                for (int k = 0; k < 16; k++) wb_line[k*32 +: 32] = $urandom;
            end
            if (reset_beat > 0 && r_cnt == reset_beat) begin
                resetn = 0;
                #1;
                chk({tag, "_rst_ctrl"}, {refresh, busy, arvalid, awvalid, wvalid, wlast, rready, bready,
                                         araddr, awaddr, wdata}, 0);
                chk({tag, "_rst_line"}, refill_line, 0);
                @(negedge clk); #1;
                resetn = 1; miss = 0;
                ref_line = '0;
                return;
            end
            if (refresh) begin found = 1; break; end
        end
        if (!found) begin
            n_checks++; n_fail++;
            $display("FAIL %s_timeout: got no refresh expected refresh within 4000 cycles", tag);
            miss = 0;
            return;
        end
        if (v.exp_lat >= 0) chk({tag, "_latency"}, (cyc + 1) - miss_edge, v.exp_lat);
        for (int i = 0; i < v.rlen; i++) ref_line[(i % 16)*32 +: 32] = s_rbeats[i];
        chk({tag, "_line"}, refill_line, ref_line);
        // miss was still high on the DONE edge; the tag now hits, so drop it
        @(negedge clk); #1;
        miss = 0;
        chk({tag, "_refresh_pulse"}, {refresh, busy}, 2'b00);
        repeat (3) @(negedge clk);
        #1;
        chk({tag, "_ar_count"}, ar_cnt, 1);
        chk({tag, "_ar_addr_len"}, {ar_addr_seen, arlen_seen}, {v.raddr, 8'd15});
        chk({tag, "_r_beats"}, r_cnt, v.rlen);
        chk({tag, "_aw_count"}, aw_cnt, v.wb ? 1 : 0);
        chk({tag, "_stable"}, stable_viol, 0);
        chk({tag, "_line_held"}, refill_line, ref_line);
        if (v.wb) begin
            chk({tag, "_aw_addr_len"}, {aw_addr_seen, awlen_seen}, {v.waddr, 8'd15});
            chk({tag, "_w_count"}, w_cnt, 16);
            for (int i = 0; i < 16; i++)
                chk($sformatf("%s_wbeat%0d", tag, i), w_seen[i], {(i == 15) ? 1'b1 : 1'b0, wbw[i]});
            chk({tag, "_b_then_ar"}, {b_cnt, ar_before_b}, {32'd1, 1'b0});
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got no finish expected finish before time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t tbl [0:4];
        vec_t v;
        logic [31:0] tmp;
        resetn = 0; miss = 0; write_back = 0; axi_raddr = 0; axi_waddr = 0; wb_line = '0;
        zw = 1; exp_wb = 0; s_rlen = 16; ref_line = '0;
        ar_cnt = 0; aw_cnt = 0; w_cnt = 0; r_cnt = 0; b_cnt = 0; stable_viol = 0; ar_before_b = 0;

        //             wb  raddr          waddr          zw rlen pat lat
        tbl[0] = '{1'b0, 32'h1FC0_0040, 32'h0000_0000, 1'b1, 16, 0, 18};
        tbl[1] = '{1'b1, 32'h2000_0080, 32'h0000_1000, 1'b1, 16, 0, 36};
        tbl[2] = '{1'b0, 32'h0000_0400, 32'h0000_0000, 1'b1,  5, 1,  7};
        tbl[3] = '{1'b0, 32'h8000_0FC0, 32'h0000_0000, 1'b1, 20, 1, 22};
        tbl[4] = '{1'b1, 32'h4000_0040, 32'h7FFF_FFC0, 1'b1, 16, 1, 36};

        #12;
        chk("reset_ctrl", {refresh, busy, arvalid, awvalid, wvalid, wlast, rready, bready,
                           araddr, awaddr, wdata}, 0);
        chk("reset_line", refill_line, 0);
        chk("ax_len_const", {arlen, awlen}, {8'd15, 8'd15});
        @(negedge clk);
        resetn = 1;

        for (int i = 0; i < 5; i++) run_txn(tbl[i], 1'b0, 0, $sformatf("vec%0d", i));

        for (int t = 0; t < 12; t++) begin
            tmp = $urandom; v.wb = tmp[0];
            tmp = $urandom; v.raddr = tmp & 32'hFFFF_FFC0;
            tmp = $urandom; v.waddr = tmp & 32'hFFFF_FFC0;
            v.zw = 1'b0;
            v.rlen = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 20)) : 16;
            v.pat = 1;
            v.exp_lat = -1;
            run_txn(v, 1'b1, 0, $sformatf("rand%0d", t));
        end

        v = '{1'b0, 32'h1234_5600, 32'h0, 1'b1, 16, 1, 18};
        run_txn(v, 1'b0, 7, "rst_mid");
        v = '{1'b0, 32'h0ABC_DE40, 32'h0, 1'b1, 16, 1, 18};
        run_txn(v, 1'b0, 0, "post_rst");
        v = '{1'b1, 32'h0000_2000, 32'h0000_3000, 1'b0, 16, 1, -1};
        run_txn(v, 1'b1, 0, "dirty_stall");

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/cache_axi_refill.md
CACHE_AXI_REFILL -- requirements
Module: cache_axi_refill

Interface
REQ-001 SHALL have no parameters; line = 16 words x 32 bit, burst length fixed at 16 beats.
REQ-002 clk  in  1  single clock; all state updates on rising edge.
REQ-003 resetn  in  1  asynchronous, active-low reset.
REQ-004 miss  in  1  tag-stage miss request; held high while the tag stage stalls.
REQ-005 write_back  in  1  victim line valid, must be written out before refill; sampled with miss.
REQ-006 axi_raddr  in  32  line-aligned refill address; sampled with miss.
REQ-007 axi_waddr  in  32  line-aligned victim address; sampled with miss.
REQ-008 wb_line  in  512  victim line from data array, word0 = bits 31:0; sampled with miss.
REQ-009 refresh  out  1  one-cycle pulse: install refill_line and the new tag.
REQ-010 refill_line  out  512  assembled refill data, word0 = bits 31:0.
REQ-011 busy  out  1  high in every state except IDLE.
REQ-012 araddr/arlen/arvalid  out  32/8/1  read address channel; arlen constant 8'd15.
REQ-013 arready  in  1  read address accept.
REQ-014 rdata/rvalid/rlast  in  32/1/1  read data channel.
REQ-015 rready  out  1  read data accept.
REQ-016 awaddr/awlen/awvalid  out  32/8/1  write address channel; awlen constant 8'd15.
REQ-017 awready  in  1  write address accept.
REQ-018 wdata/wlast/wvalid  out  32/1/1  write data channel.
REQ-019 wready  in  1  write data accept.
REQ-020 bvalid  in  1, bready  out  1  write response channel; response code ignored.

Function
REQ-021 FSM states: IDLE, AW, W, B, AR, R, DONE; one-hot or encoded, implementer's choice.
REQ-022 IDLE & miss: capture axi_raddr, axi_waddr, wb_line, write_back; next = AW if write_back else AR.
REQ-023 AW: awvalid=1, awaddr=captured waddr; on awready -> W.
REQ-024 W: wvalid=1, wdata = captured word[cnt]; cnt (4 bit) increments per wready handshake; wlast=1 when cnt=15; handshake with wlast -> B, cnt cleared.
REQ-025 B: bready=1; on bvalid -> AR.
REQ-026 AR: arvalid=1, araddr=captured raddr; on arready -> R.
REQ-027 R: rready=1; each rvalid writes rdata into refill_line word[cnt], cnt++ (wraps 15->0); rvalid & rlast -> DONE, cnt cleared; rlast is authoritative, unwritten words keep prior value.
REQ-028 DONE: refresh=1 for exactly one cycle, then IDLE unconditionally.
REQ-029 Every valid output SHALL stay high with stable address/data until its ready handshake.
REQ-030 miss while busy, including in DONE, SHALL be ignored; no request queuing.
REQ-031 A started transaction always completes; there is no abort input.
REQ-032 refill_line stable from DONE until the next R-state beat.
REQ-033 Zero-wait latency: refresh 18 cycles after miss sampled (no write_back), 36 cycles with write_back.

Reset
REQ-034 resetn low SHALL immediately force state IDLE, cnt 0, refill_line 0, captured regs 0, all valid/ready/refresh/busy/wlast outputs 0.
REQ-035 Reset mid-burst SHALL abandon the burst; the first miss after release starts a fresh transaction.

Verification
REQ-036 Clean miss, zero-wait slave, raddr=0x1FC0_0040, rdata=beat index -> araddr 0x1FC0_0040, arlen 15, refresh at cycle 18, refill_line word k = k.
REQ-037 Dirty miss, waddr=0x0000_1000, wb_line word k = 0xA000_0000+k -> 16 W beats in order, wlast on beat 16, AR only after bvalid, refresh at cycle 36.
REQ-038 Random arready/awready/wready/rvalid stalls -> valids and data held stable, no lost or duplicated beat, final line correct.
REQ-039 miss held high through DONE and the following IDLE, with the tag hitting after refresh -> exactly one AR burst issued.
REQ-040 resetn pulsed low at R beat 7 -> outputs 0 immediately; next miss runs a full 16-beat burst from word 0.
